// File: rtl/iter_sched.sv
`default_nettype none
// iter_sched: LDPC iteration scheduler that sequences channel load, VN/CN circulant
// steps and syndrome checks until convergence or MAX_ITER iterations.
module iter_sched #(
  parameter int MAX_ITER      = 30,
  parameter int LOG2MAX_ITER  = 5,
  parameter int CIRC_SIZE     = 3,
  parameter int LOG2CIRC_SIZE = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start_i,
  input  logic                     abort_i,
  input  logic                     load_done_i,
  input  logic                     step_ack_i,
  input  logic                     syn_valid_i,
  input  logic                     syn_zero_i,
  output logic [3:0]               state_o,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     success_o,
  output logic [LOG2MAX_ITER-1:0]  iter_count_o,
  output logic                     load_req_o,
  output logic                     step_req_o,
  output logic                     vr_process_o,
  output logic                     neighbor_o,
  output logic                     syndrome_o,
  output logic [LOG2CIRC_SIZE-1:0] circ_node_o
);

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_LOAD = 4'd1,
    S_VN   = 4'd2,
    S_CN   = 4'd3,
    S_SYN  = 4'd4,
    S_DONE = 4'd5
  } state_t;

  localparam logic [LOG2MAX_ITER-1:0]  C_ITER_LAST = LOG2MAX_ITER'(MAX_ITER - 1);
  localparam logic [LOG2CIRC_SIZE-1:0] C_CIRC_LAST = LOG2CIRC_SIZE'(CIRC_SIZE - 1);

  state_t                     state_q, state_d;
  logic [LOG2MAX_ITER-1:0]    iter_q, iter_d;
  logic [LOG2CIRC_SIZE-1:0]   circ_q, circ_d;
  logic                       success_q, success_d;
  logic                       load_req_q, step_req_q, vr_q, nb_q, syn_q, done_q, busy_q;

  always_comb begin
    state_d   = state_q;
    iter_d    = iter_q;
    circ_d    = circ_q;
    success_d = success_q;
    if (abort_i && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      circ_d  = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            state_d   = S_LOAD;
            iter_d    = '0;
            circ_d    = '0;
            success_d = 1'b0;
          end
        end
        S_LOAD: begin
          if (load_done_i) state_d = S_VN;
        end
        S_VN, S_CN: begin
          if (step_ack_i) begin
            if (circ_q == C_CIRC_LAST) begin
              circ_d  = '0;
              state_d = (state_q == S_VN) ? S_CN : S_SYN;
            end else begin
              circ_d = circ_q + LOG2CIRC_SIZE'(1);
            end
          end
        end
        S_SYN: begin
          // A zero syndrome wins even on the final permitted iteration.
          if (syn_valid_i) begin
            if (syn_zero_i) begin
              success_d = 1'b1;
              state_d   = S_DONE;
            end else if (iter_q == C_ITER_LAST) begin
              success_d = 1'b0;
              state_d   = S_DONE;
            end else begin
              iter_d  = iter_q + LOG2MAX_ITER'(1);
              state_d = S_VN;
            end
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Decoded outputs are registered from the next state so they align with state_q.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      iter_q     <= '0;
      circ_q     <= '0;
      success_q  <= 1'b0;
      load_req_q <= 1'b0;
      step_req_q <= 1'b0;
      vr_q       <= 1'b0;
      nb_q       <= 1'b0;
      syn_q      <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      iter_q     <= iter_d;
      circ_q     <= circ_d;
      success_q  <= success_d;
      load_req_q <= (state_d == S_LOAD);
      step_req_q <= (state_d == S_VN) || (state_d == S_CN);
      vr_q       <= (state_d == S_VN);
      nb_q       <= (state_d == S_CN);
      syn_q      <= (state_d == S_SYN);
      done_q     <= (state_d == S_DONE);
      busy_q     <= (state_d != S_IDLE);
    end
  end

  assign state_o      = state_q;
  assign iter_count_o = iter_q;
  assign circ_node_o  = circ_q;
  assign success_o    = success_q;
  assign load_req_o   = load_req_q;
  assign step_req_o   = step_req_q;
  assign vr_process_o = vr_q;
  assign neighbor_o   = nb_q;
  assign syndrome_o   = syn_q;
  assign done_o       = done_q;
  assign busy_o       = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_iter_sched.sv
`default_nettype none
// tb_iter_sched: directed and randomized checks of iter_sched against a
// transaction-level schedule model.
module tb_iter_sched;

  localparam int MAX  = 30;
  localparam int CIRC = 3;
  localparam int LI   = 5;
  localparam int LC   = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start_i = 1'b0, abort_i = 1'b0, load_done_i = 1'b0;
  logic step_ack_i = 1'b0, syn_valid_i = 1'b0, syn_zero_i = 1'b0;
  logic [3:0]    state_o;
  logic          busy_o, done_o, success_o;
  logic [LI-1:0] iter_count_o;
  logic          load_req_o, step_req_o, vr_process_o, neighbor_o, syndrome_o;
  logic [LC-1:0] circ_node_o;

  int checks = 0;
  int errors = 0;

  iter_sched #(.MAX_ITER(MAX), .LOG2MAX_ITER(LI), .CIRC_SIZE(CIRC), .LOG2CIRC_SIZE(LC)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .abort_i(abort_i),
    .load_done_i(load_done_i), .step_ack_i(step_ack_i),
    .syn_valid_i(syn_valid_i), .syn_zero_i(syn_zero_i),
    .state_o(state_o), .busy_o(busy_o), .done_o(done_o), .success_o(success_o),
    .iter_count_o(iter_count_o), .load_req_o(load_req_o), .step_req_o(step_req_o),
    .vr_process_o(vr_process_o), .neighbor_o(neighbor_o), .syndrome_o(syndrome_o),
    .circ_node_o(circ_node_o)
  );

  always #5 clk = ~clk;

  // One planned clock edge: inputs applied before it, expected view after it.
  typedef struct {
    logic       st, ld, sa, sv, sz;
    logic [3:0] es;
    int         ec, ei;
    logic       esu;
  } plan_t;

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic plan_t mk(input logic st, ld, sa, sv, sz, input logic [3:0] es,
                               input int ec, ei, input logic esu);
    plan_t p;
    p.st = st; p.ld = ld; p.sa = sa; p.sv = sv; p.sz = sz;
    p.es = es; p.ec = ec; p.ei = ei; p.esu = esu;
    return p;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    start_i = 1'b0; abort_i = 1'b0; load_done_i = 1'b0;
    step_ack_i = 1'b0; syn_valid_i = 1'b0; syn_zero_i = 1'b0;
  endtask

  task automatic reset_dut();
    drive_idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({state_o, iter_count_o, circ_node_o, success_o, load_req_o, step_req_o, vr_process_o,
         neighbor_o, syndrome_o, done_o, busy_o} !== '0)
      begin errors++; $display("FAIL reset_async: state=%0d iter=%0d circ=%0d busy=%b done=%b required all zero",
                                state_o, iter_count_o, circ_node_o, busy_o, done_o); end
    start_i = 1'b1;
    tick();
    checks++;
    if (state_o !== 4'd0) begin errors++; $display("FAIL reset_hold: state=%0d required 0", state_o); end
    rst = 1'b0;
    #2;
    checks++;
    if (state_o !== 4'd0) begin errors++; $display("FAIL reset_release: state=%0d required 0", state_o); end
    tick();
    checks++;
    if (state_o !== 4'd1 || load_req_o !== 1'b1)
      begin errors++; $display("FAIL reset_first_start: state=%0d load_req=%b required 1/1", state_o, load_req_o); end
    drive_idle();
  endtask

  task automatic test_converge_first();
    int n;
    reset_dut();
    load_done_i = 1'b1; step_ack_i = 1'b1; syn_valid_i = 1'b1; syn_zero_i = 1'b1; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    checks++;
    if (state_o !== 4'd1 || busy_o !== 1'b1)
      begin errors++; $display("FAIL conv_first_load: state=%0d busy=%b required 1/1", state_o, busy_o); end
    n = 0;
    while (n < 20 && done_o !== 1'b1) begin tick(); n++; end
    checks++;
    if (n != 8) begin errors++; $display("FAIL conv_first_latency: edges=%0d required 8", n); end
    checks++;
    if (success_o !== 1'b1 || iter_count_o !== LI'(0))
      begin errors++; $display("FAIL conv_first_result: success=%b iter=%0d required 1/0", success_o, iter_count_o); end
    tick();
    checks++;
    if (done_o !== 1'b0 || state_o !== 4'd0 || success_o !== 1'b1 || iter_count_o !== LI'(0))
      begin errors++; $display("FAIL conv_first_after: done=%b state=%0d success=%b iter=%0d required 0/0/1/0",
                                done_o, state_o, success_o, iter_count_o); end
    drive_idle();
  endtask

  task automatic test_max_iter();
    int n;
    reset_dut();
    load_done_i = 1'b1; step_ack_i = 1'b1; syn_valid_i = 1'b1; syn_zero_i = 1'b0; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    n = 0;
    while (n < 400 && done_o !== 1'b1) begin tick(); n++; end
    checks++;
    if (n != 1 + CIRC * 2 + (MAX - 1) * (2 * CIRC + 1) + 1)
      begin errors++; $display("FAIL max_iter_latency: edges=%0d required %0d", n,
                                1 + CIRC * 2 + (MAX - 1) * (2 * CIRC + 1) + 1); end
    checks++;
    if (success_o !== 1'b0 || iter_count_o !== LI'(MAX - 1))
      begin errors++; $display("FAIL max_iter_result: success=%b iter=%0d required 0/%0d",
                                success_o, iter_count_o, MAX - 1); end
    drive_idle();
  endtask

  // conv is the iteration on which the syndrome first reads zero (MAX = never).
  task automatic run_codeword(input int conv, input int dmax, input string tag);
    plan_t      plan[$];
    int         d, fin_it;
    logic       fin_su;
    logic [3:0] es;
    logic [6:0] exp_o, got_o;
    fin_it = 0;
    fin_su = 1'b0;
    plan.push_back(mk(1'b1, rb(), rb(), rb(), rb(), 4'd1, 0, 0, 1'b0));
    d = $urandom_range(0, dmax);
    repeat (d) plan.push_back(mk(rb(), 1'b0, rb(), rb(), rb(), 4'd1, 0, 0, 1'b0));
    plan.push_back(mk(rb(), 1'b1, rb(), rb(), rb(), 4'd2, 0, 0, 1'b0));
    for (int it = 0; it < MAX; it++) begin
      for (int ph = 0; ph < 2; ph++) begin
        for (int c = 0; c < CIRC; c++) begin
          es = (ph == 0) ? 4'd2 : 4'd3;
          d = $urandom_range(0, dmax);
          repeat (d) plan.push_back(mk(rb(), rb(), 1'b0, rb(), rb(), es, c, it, 1'b0));
          if (c < CIRC - 1)
            plan.push_back(mk(rb(), rb(), 1'b1, rb(), rb(), es, c + 1, it, 1'b0));
          else
            plan.push_back(mk(rb(), rb(), 1'b1, rb(), rb(), (ph == 0) ? 4'd3 : 4'd4, 0, it, 1'b0));
        end
      end
      d = $urandom_range(0, dmax);
      repeat (d) plan.push_back(mk(rb(), rb(), rb(), 1'b0, rb(), 4'd4, 0, it, 1'b0));
      if (it == conv) begin
        plan.push_back(mk(rb(), rb(), rb(), 1'b1, 1'b1, 4'd5, 0, it, 1'b1));
        fin_it = it; fin_su = 1'b1;
        break;
      end else if (it == MAX - 1) begin
        plan.push_back(mk(rb(), rb(), rb(), 1'b1, 1'b0, 4'd5, 0, it, 1'b0));
        fin_it = it; fin_su = 1'b0;
      end else begin
        plan.push_back(mk(rb(), rb(), rb(), 1'b1, 1'b0, 4'd2, 0, it + 1, 1'b0));
      end
    end
    plan.push_back(mk(1'b0, rb(), rb(), rb(), rb(), 4'd0, 0, fin_it, fin_su));

    for (int k = 0; k < plan.size(); k++) begin
      start_i = plan[k].st; load_done_i = plan[k].ld; step_ack_i = plan[k].sa;
      syn_valid_i = plan[k].sv; syn_zero_i = plan[k].sz;
      tick();
      es = plan[k].es;
      exp_o = {es == 4'd1, es == 4'd2 || es == 4'd3, es == 4'd2, es == 4'd3,
               es == 4'd4, es == 4'd5, es != 4'd0};
      got_o = {load_req_o, step_req_o, vr_process_o, neighbor_o, syndrome_o, done_o, busy_o};
      checks++;
      if (state_o !== es || circ_node_o !== LC'(plan[k].ec) || iter_count_o !== LI'(plan[k].ei) ||
          success_o !== plan[k].esu || got_o !== exp_o) begin
        errors++;
        $display("FAIL %s edge %0d: state=%0d circ=%0d iter=%0d succ=%b outs=%b required state=%0d circ=%0d iter=%0d succ=%b outs=%b",
                 tag, k, state_o, circ_node_o, iter_count_o, success_o, got_o,
                 es, plan[k].ec, plan[k].ei, plan[k].esu, exp_o);
        break;
      end
    end
    drive_idle();
  endtask

  task automatic test_last_iter_converge();
    reset_dut();
    run_codeword(MAX - 1, 1, "last_iter_conv");
  endtask

  task automatic test_random();
    reset_dut();
    run_codeword(0, 0, "rand_conv0");
    for (int r = 0; r < 6; r++) run_codeword($urandom_range(0, MAX), 2, "rand_codeword");
  endtask

  task automatic test_stall();
    reset_dut();
    load_done_i = 1'b1; step_ack_i = 1'b1; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    tick();
    tick();
    checks++;
    if (state_o !== 4'd2 || circ_node_o !== LC'(1))
      begin errors++; $display("FAIL stall_setup: state=%0d circ=%0d required 2/1", state_o, circ_node_o); end
    step_ack_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (state_o !== 4'd2 || circ_node_o !== LC'(1) || step_req_o !== 1'b1)
        begin errors++; $display("FAIL stall_hold cycle %0d: state=%0d circ=%0d step_req=%b required 2/1/1",
                                  i, state_o, circ_node_o, step_req_o); end
    end
    step_ack_i = 1'b1;
    tick();
    checks++;
    if (state_o !== 4'd2 || circ_node_o !== LC'(2))
      begin errors++; $display("FAIL stall_advance: state=%0d circ=%0d required 2/2", state_o, circ_node_o); end
    drive_idle();
  endtask

  task automatic test_abort();
    logic seen_done;
    reset_dut();
    load_done_i = 1'b1; step_ack_i = 1'b1; syn_valid_i = 1'b1; syn_zero_i = 1'b1; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    repeat (6) tick();
    checks++;
    if (state_o !== 4'd3 || circ_node_o !== LC'(2))
      begin errors++; $display("FAIL abort_setup: state=%0d circ=%0d required 3/2", state_o, circ_node_o); end
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    checks++;
    if (state_o !== 4'd0 || circ_node_o !== LC'(0) || busy_o !== 1'b0 || done_o !== 1'b0)
      begin errors++; $display("FAIL abort_idle: state=%0d circ=%0d busy=%b done=%b required 0/0/0/0",
                                state_o, circ_node_o, busy_o, done_o); end
    seen_done = 1'b0;
    repeat (4) begin tick(); seen_done |= done_o; end
    checks++;
    if (seen_done !== 1'b0 || state_o !== 4'd0)
      begin errors++; $display("FAIL abort_no_done: done_seen=%b state=%0d required 0/0", seen_done, state_o); end
    abort_i = 1'b1; start_i = 1'b1;
    tick();
    drive_idle();
    checks++;
    if (state_o !== 4'd1)
      begin errors++; $display("FAIL abort_in_idle: state=%0d required 1", state_o); end
  endtask

  task automatic test_rst_mid();
    reset_dut();
    load_done_i = 1'b1; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    tick();
    checks++;
    if (state_o !== 4'd2)
      begin errors++; $display("FAIL rst_mid_setup: state=%0d required 2", state_o); end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({state_o, iter_count_o, circ_node_o, success_o, load_req_o, step_req_o, vr_process_o,
         neighbor_o, syndrome_o, done_o, busy_o} !== '0)
      begin errors++; $display("FAIL rst_mid_clear: state=%0d step_req=%b busy=%b required all zero",
                                state_o, step_req_o, busy_o); end
    tick();
    rst = 1'b0;
    drive_idle();
  endtask

  task automatic test_back_to_back();
    int n;
    reset_dut();
    load_done_i = 1'b1; step_ack_i = 1'b1; syn_valid_i = 1'b1; syn_zero_i = 1'b1; start_i = 1'b1;
    tick();
    n = 0;
    while (n < 20 && done_o !== 1'b1) begin tick(); n++; end
    checks++;
    if (n != 8) begin errors++; $display("FAIL b2b_latency: edges=%0d required 8", n); end
    tick();
    checks++;
    if (state_o !== 4'd0 || success_o !== 1'b1)
      begin errors++; $display("FAIL b2b_idle: state=%0d success=%b required 0/1", state_o, success_o); end
    tick();
    checks++;
    if (state_o !== 4'd1 || success_o !== 1'b0 || iter_count_o !== LI'(0))
      begin errors++; $display("FAIL b2b_restart: state=%0d success=%b iter=%0d required 1/0/0",
                                state_o, success_o, iter_count_o); end
    drive_idle();
  endtask

  initial begin
    test_reset();
    test_converge_first();
    test_max_iter();
    test_last_iter_converge();
    test_stall();
    test_abort();
    test_rst_mid();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/iter_sched.md
ITER_SCHED -- requirements
Module: iter_sched

Interface
REQ-001 Parameter MAX_ITER, default 30, maximum decoding iterations per codeword.
REQ-002 Parameter LOG2MAX_ITER, default 5, width of iteration counter.
REQ-003 Parameter CIRC_SIZE, default 3, circulant steps per processing phase.
REQ-004 Parameter LOG2CIRC_SIZE, default 2, width of circulant index.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 start  input  1  begin decoding a codeword; sampled only in IDLE.
REQ-008 abort  input  1  synchronous abort to IDLE from any state.
REQ-009 load_done  input  1  channel-value load complete; sampled only in LOAD.
REQ-010 step_ack  input  1  memory fetcher finished current circulant step; sampled only when step_req=1.
REQ-011 syn_valid  input  1  syndrome result valid; sampled only in SYN.
REQ-012 syn_zero  input  1  all parity checks satisfied; qualified by syn_valid.
REQ-013 state  output  4  current FSM encoding.
REQ-014 busy  output  1  high in any state other than IDLE.
REQ-015 done  output  1  one-cycle completion pulse.
REQ-016 success  output  1  last codeword converged; held until next accepted start.
REQ-017 iter_count  output  LOG2MAX_ITER  0-based index of current/last iteration.
REQ-018 load_req  output  1  request channel-value load.
REQ-019 step_req  output  1  request one circulant step from memory fetcher.
REQ-020 vr_process  output  1  variable-node phase select.
REQ-021 neighbor  output  1  check-node (neighbor message) phase select.
REQ-022 syndrome  output  1  syndrome check request.
REQ-023 circ_node  output  LOG2CIRC_SIZE  current circulant index.

Function
REQ-024 States: IDLE=0, LOAD=1, VN=2, CN=3, SYN=4, DONE=5; encodings 6-15 shall transition to IDLE.
REQ-025 Outputs decoded from state: load_req=LOAD; vr_process=VN; neighbor=CN; step_req=VN|CN; syndrome=SYN; done=DONE; busy=state!=IDLE.
REQ-026 IDLE: start=1 -> LOAD; iter_count<=0, circ_node<=0, success<=0.
REQ-027 LOAD: load_done=1 -> VN; otherwise hold.
REQ-028 VN: step_ack=1 and circ_node<CIRC_SIZE-1 -> circ_node+1; step_ack=1 and circ_node=CIRC_SIZE-1 -> circ_node<=0, go CN; step_ack=0 -> hold all.
REQ-029 CN: same stepping rule as VN; last step -> circ_node<=0, go SYN.
REQ-030 SYN: syn_valid=1 and syn_zero=1 -> success<=1, DONE.
REQ-031 SYN: syn_valid=1, syn_zero=0, iter_count=MAX_ITER-1 -> success<=0, DONE; iter_count unchanged.
REQ-032 SYN: syn_valid=1, syn_zero=0, iter_count<MAX_ITER-1 -> iter_count+1, VN.
REQ-033 SYN with syn_valid=0 -> hold.
REQ-034 DONE lasts exactly one cycle, then IDLE unconditionally; iter_count and success hold in IDLE.
REQ-035 Convergence on the final permitted iteration shall report success=1 (syn_zero priority over limit).
REQ-036 abort=1 in any non-IDLE state -> IDLE next edge, circ_node<=0, no done pulse; abort has priority over all other inputs; abort in IDLE has no effect.
REQ-037 start while busy shall be ignored; start held high across DONE shall begin a new codeword from IDLE on the following edge.
REQ-038 load_done, step_ack, syn_valid outside their qualifying state shall be ignored.
REQ-039 circ_node shall never exceed CIRC_SIZE-1; iter_count shall never exceed MAX_ITER-1.

Reset
REQ-040 rst=1 shall immediately force state=IDLE, iter_count=0, circ_node=0, success=0; all decoded outputs 0.
REQ-041 rst deassertion shall take effect on the next rising clk edge; start sampled no earlier than that edge.

Verification
REQ-042 start pulse, load_done/step_ack/syn_valid/syn_zero held 1 -> done=1 exactly 8 edges after start edge, success=1, iter_count=0.
REQ-043 as REQ-042 but syn_zero=0 -> 30 VN/CN/SYN rounds, done with success=0, iter_count=29.
REQ-044 syn_zero=1 only on iteration index 29 -> success=1, iter_count=29.
REQ-045 step_ack low 5 cycles in VN at circ_node=1 -> circ_node, state, step_req held 5 cycles, then advance to 2.
REQ-046 abort in CN at circ_node=2 -> IDLE next edge, circ_node=0, busy=0, no done pulse.
REQ-047 rst asserted mid-VN between edges -> state=0, outputs cleared before next edge; start during busy produces no restart.
